// File: rtl/mult_seq_n.sv
// Sequential signed shift-and-add multiplier: one partial product per clock, final step subtracts.
// Optional overflow detector enabled by defining MULT_SEQ_OVF_EN.
module mult_seq_n #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] m_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             x_out,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic             ovf,
  output logic [1:0]       state_dbg
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    k_q;
  logic             x_q;
  logic [WIDTH-1:0] a_q, b_q, m_q;
  logic             busy_q, done_q;

  logic             last_k;
  logic [WIDTH:0]   a_ext, m_ext, s;
  logic             x_d;
  logic [WIDTH-1:0] a_d, b_d;

  assign last_k = (k_q == CW'(WIDTH - 1));
  assign a_ext  = {a_q[WIDTH-1], a_q};
  assign m_ext  = {m_q[WIDTH-1], m_q};

  // The multiplier's top bit carries negative weight, so the last step subtracts.
  always_comb begin
    s = a_ext;
    if (b_q[0]) begin
      s = last_k ? (a_ext - m_ext) : (a_ext + m_ext);
    end
  end

  assign x_d = s[WIDTH];
  assign a_d = {s[WIDTH], s[WIDTH-1:1]};
  assign b_d = {s[0], b_q[WIDTH-1:1]};

`ifdef MULT_SEQ_OVF_EN
  logic ovf_q;
  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      x_q     <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef MULT_SEQ_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            m_q     <= m_in;
            b_q     <= b_in;
            x_q     <= 1'b0;
            a_q     <= '0;
            k_q     <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
`ifdef MULT_SEQ_OVF_EN
            ovf_q   <= 1'b0;
`endif
          end
        end
        RUN: begin
          x_q <= x_d;
          a_q <= a_d;
          b_q <= b_d;
          k_q <= k_q + CW'(1);
          if (last_k) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
`ifdef MULT_SEQ_OVF_EN
            ovf_q   <= (a_d != {WIDTH{b_d[WIDTH-1]}});
`endif
          end
        end
        DONE: begin
          // Leaving only on start low forces a low-then-high for the next operation.
          if (!start) begin
            done_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign x_out     = x_q;
  assign a_out     = a_q;
  assign b_out     = b_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_mult_seq_n.sv
// Bench for mult_seq_n: directed vector table, randomized operands against an arithmetic model,
// start-hold and mid-run reset sequences, plus a WIDTH=16 instance.
module tb_mult_seq_n;

  logic        Clk = 1'b0;
  logic        reset_n = 1'b0;

  logic        start8 = 1'b0;
  logic [7:0]  m8 = '0, b8 = '0;
  logic        busy8, done8, x8, ovf8;
  logic [7:0]  a8, bo8;
  logic [1:0]  st8;

  logic        start16 = 1'b0;
  logic [15:0] m16 = '0, b16 = '0;
  logic        busy16, done16, x16, ovf16;
  logic [15:0] a16, bo16;
  logic [1:0]  st16;

  int n_vec = 0;
  int n_err = 0;

  always #5 Clk = ~Clk;

  mult_seq_n #(.WIDTH(8)) dut8 (
    .Clk(Clk), .reset_n(reset_n), .start(start8), .m_in(m8), .b_in(b8),
    .busy(busy8), .done(done8), .x_out(x8), .a_out(a8), .b_out(bo8),
    .ovf(ovf8), .state_dbg(st8)
  );

  mult_seq_n #(.WIDTH(16)) dut16 (
    .Clk(Clk), .reset_n(reset_n), .start(start16), .m_in(m16), .b_in(b16),
    .busy(busy16), .done(done16), .x_out(x16), .a_out(a16), .b_out(bo16),
    .ovf(ovf16), .state_dbg(st16)
  );

  typedef struct {
    logic [7:0] m;
    logic [7:0] b;
    logic       x;
    logic [7:0] a;
    logic [7:0] lo;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Reference: exact signed product by plain arithmetic.
  function automatic logic [15:0] ref8(input logic [7:0] m, input logic [7:0] b);
    int p;
    p = $signed(m) * $signed(b);
    return p[15:0];
  endfunction

  function automatic logic ref_ovf8(input logic [15:0] p);
`ifdef MULT_SEQ_OVF_EN
    int v;
    v = $signed(p);
    return (v > 127 || v < -128);
`else
    return 1'b0 & p[0];
`endif
  endfunction

  // Runs one WIDTH=8 multiply; checks latency, busy length, result, DONE hold and IDLE hold.
  task automatic op8(input logic [7:0] m, input logic [7:0] b, input bit hold_start, input string nm);
    int n;
    int bc;
    logic [15:0] p;
    p = ref8(m, b);
    @(negedge Clk);
    m8 = m; b8 = b; start8 = 1'b1;
    @(posedge Clk); #1;
    if (!hold_start) start8 = 1'b0;
    m8 = 8'($urandom); b8 = 8'($urandom);
    n = 0;
    bc = busy8 ? 1 : 0;
    while (!done8 && n < 12) begin
      @(posedge Clk); #1;
      n++;
      if (busy8) bc++;
      if (busy8 && done8) chk({nm, "_busy_and_done"}, 1, 0);
      if (n == 3) start8 = ~start8;
    end
    if (n == 3 && !hold_start) start8 = 1'b0;
    if (hold_start) start8 = 1'b1; else start8 = 1'b0;
    chk({nm, "_latency"}, 64'(n), 64'd8);
    chk({nm, "_busy_cycles"}, 64'(bc), 64'd8);
    chk({nm, "_product"}, {47'd0, x8, a8, bo8}, {47'd0, p[15], p});
    chk({nm, "_ovf"}, 64'(ovf8), 64'(ref_ovf8(p)));
    if (hold_start) begin
      repeat (3) @(posedge Clk);
      #1;
      chk({nm, "_hold_done"}, {46'd0, busy8, done8, x8, a8, bo8}, {46'd0, 1'b0, 1'b1, p[15], p});
      start8 = 1'b0;
    end
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    chk({nm, "_idle_hold"}, {46'd0, busy8, done8, x8, a8, bo8}, {46'd0, 1'b0, 1'b0, p[15], p});
  endtask

  task automatic op16(input logic [15:0] m, input logic [15:0] b, input string nm);
    int n;
    int p;
    p = $signed(m) * $signed(b);
    @(negedge Clk);
    m16 = m; b16 = b; start16 = 1'b1;
    @(posedge Clk); #1;
    start16 = 1'b0;
    n = 0;
    while (!done16 && n < 24) begin
      @(posedge Clk); #1;
      n++;
    end
    chk({nm, "_latency"}, 64'(n), 64'd16);
    chk({nm, "_product"}, {31'd0, x16, a16, bo16}, {31'd0, p[31], p});
    @(posedge Clk); #1;
  endtask

  vec_t tbl[$];

  initial begin
    tbl.push_back('{8'h07, 8'hFD, 1'b1, 8'hFF, 8'hEB});
    tbl.push_back('{8'h80, 8'h80, 1'b0, 8'h40, 8'h00});
    tbl.push_back('{8'h05, 8'h00, 1'b0, 8'h00, 8'h00});
    tbl.push_back('{8'h00, 8'h7F, 1'b0, 8'h00, 8'h00});
    tbl.push_back('{8'h7F, 8'h7F, 1'b0, 8'h3F, 8'h01});
    tbl.push_back('{8'hFF, 8'hFF, 1'b0, 8'h00, 8'h01});
    tbl.push_back('{8'h80, 8'h7F, 1'b1, 8'hC0, 8'h80});

    repeat (2) @(posedge Clk);
    #1;
    chk("reset_outputs", {45'd0, busy8, done8, x8, a8, bo8, ovf8}, 64'd0);
    chk("reset_state", 64'(st8), 64'd0);
    @(negedge Clk);
    reset_n = 1'b1;

    foreach (tbl[i]) begin
      op8(tbl[i].m, tbl[i].b, 1'b0, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d_const", i), {47'd0, x8, a8, bo8}, {47'd0, tbl[i].x, tbl[i].a, tbl[i].lo});
    end

    // start held high through DONE, then a fresh low-then-high start.
    op8(8'h13, 8'hF7, 1'b1, "hold_a");
    op8(8'hC5, 8'h2B, 1'b0, "hold_b");

    for (int i = 0; i < 20; i++) begin
      op8(8'($urandom), 8'($urandom), 1'b0, $sformatf("rnd%0d", i));
    end

    // Reset pulsed while iterating at k=3.
    @(negedge Clk);
    m8 = 8'h6B; b8 = 8'h9D; start8 = 1'b1;
    @(posedge Clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("midrun_reset", {45'd0, busy8, done8, x8, a8, bo8, ovf8}, 64'd0);
    chk("midrun_reset_state", 64'(st8), 64'd0);
    @(negedge Clk);
    reset_n = 1'b1;
    @(posedge Clk); #1;
    chk("after_reset_idle", {45'd0, busy8, done8, x8, a8, bo8, ovf8}, 64'd0);
    op8(8'h6B, 8'h9D, 1'b0, "post_reset");

    op16(16'd300, 16'hFF38, "w16_spec");
    chk("w16_spec_const", {32'd0, a16, bo16}, 64'h00000000FFFF15A0);
    for (int i = 0; i < 6; i++) begin
      op16(16'($urandom), 16'($urandom), $sformatf("w16_rnd%0d", i));
    end
    op16(16'h8000, 16'h8000, "w16_min");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
